ysyx_23060077_csr_trap: RTL and testbench



---
 rtl/ysyx_23060077_csr_trap.sv | 225 ++++++++++++++++++++++
 tb/tb_ysyx_23060077_csr_trap.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_csr_trap.sv
// ============================================================================
// Module  : ysyx_23060077_csr_trap
// Brief   : Machine-mode CSR file with integrated trap/interrupt unit,
//           free-running mcycle/minstret counters and a registered fetch
//           redirect. Optional macro CSR_VECTORED_MTVEC_EN enables vectored
//           mtvec mode (interrupts to base + 4*cause).
// Revision: 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module ysyx_23060077_csr_trap #(
  parameter int          XLEN          = 32,
  parameter logic [31:0] MVENDORID_VAL = 32'h7973_7978,
  parameter logic [31:0] MARCHID_VAL   = 32'h015F_DE7D,
  parameter int          CNT_WIDTH     = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            csr_en,
  input  logic [2:0]      funct3,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic [XLEN-1:0] csr_rd_data,
  output logic            csr_illegal,
  input  logic            ecall_i,
  input  logic            illegal_i,
  input  logic            mret_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] npc_i,
  input  logic            boundary_i,
  input  logic            instret_i,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] csr_mstatus,
  output logic            irq_taken
);

  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_mie       = 12'h304;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mtval     = 12'h343;
  localparam logic [11:0] c_addr_mip       = 12'h344;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_minstret  = 12'hB02;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_minstreth = 12'hB82;
  localparam logic [11:0] c_addr_mvendorid = 12'hF11;
  localparam logic [11:0] c_addr_marchid   = 12'hF12;

  // Counters are viewed through a 2*XLEN window so the high-half address
  // is only meaningful when the counter is wider than a CSR.
  localparam int            c_wide       = 2 * XLEN;
  localparam bit            c_has_hi     = (CNT_WIDTH > XLEN);
  localparam logic [XLEN-1:0] c_irq_mask = XLEN'(12'h880);
  localparam logic [XLEN-1:0] c_align4   = ~XLEN'(3);
`ifdef CSR_VECTORED_MTVEC_EN
  localparam logic [XLEN-1:0] c_mtvec_mask = '1;
`else
  localparam logic [XLEN-1:0] c_mtvec_mask = ~XLEN'(3);
`endif

  logic            r_mie_bit, r_mpie_bit;
  logic [XLEN-1:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [CNT_WIDTH-1:0] r_mcycle, r_minstret;

  logic [XLEN-1:0] w_mstatus, w_mip, w_old, w_new, w_mcause, w_trap_pc, w_vec_off;
  logic [c_wide-1:0] w_cyc_view, w_ins_view, w_cyc_next, w_ins_next;
  logic            w_impl, w_ro, w_wr_req, w_csr_we;
  logic            w_irq_ext, w_irq_tmr, w_irq, w_trap, w_mret;
  logic [3:0]      w_cause_code;

  // MPP is hardwired to machine mode; only MIE/MPIE are stored.
  assign w_mstatus   = XLEN'({2'b11, 3'b000, r_mpie_bit, 3'b000, r_mie_bit, 3'b000});
  assign w_mip       = XLEN'({irq_ext, 3'b000, irq_timer, 7'b0000000});
  assign w_cyc_view  = c_wide'(r_mcycle);
  assign w_ins_view  = c_wide'(r_minstret);
  assign csr_mstatus = w_mstatus;

  // Combinational CSR read mux with implemented/read-only classification
  always_comb begin
    w_impl = 1'b1;
    w_ro   = 1'b0;
    w_old  = '0;
    case (csr_addr)
      c_addr_mstatus:   w_old = w_mstatus;
      c_addr_mie:       w_old = r_mie;
      c_addr_mtvec:     w_old = r_mtvec;
      c_addr_mscratch:  w_old = r_mscratch;
      c_addr_mepc:      w_old = r_mepc;
      c_addr_mcause:    w_old = r_mcause;
      c_addr_mtval:     w_old = r_mtval;
      c_addr_mip:       begin w_old = w_mip; w_ro = 1'b1; end
      c_addr_mcycle:    w_old = w_cyc_view[XLEN-1:0];
      c_addr_minstret:  w_old = w_ins_view[XLEN-1:0];
      c_addr_mcycleh:   begin w_old = w_cyc_view[c_wide-1:XLEN]; w_impl = c_has_hi; end
      c_addr_minstreth: begin w_old = w_ins_view[c_wide-1:XLEN]; w_impl = c_has_hi; end
      c_addr_mvendorid: begin w_old = XLEN'(MVENDORID_VAL); w_ro = 1'b1; end
      c_addr_marchid:   begin w_old = XLEN'(MARCHID_VAL); w_ro = 1'b1; end
      default:          w_impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never counts as a write.
  assign w_wr_req    = (funct3[1:0] == 2'b01) ||
                       (funct3[1:0] != 2'b00 && (|csr_wr_data));
  assign csr_illegal = csr_en && (!w_impl || (w_ro && w_wr_req));
  assign csr_rd_data = (csr_en && w_impl) ? w_old : '0;

  // Read-modify-write value for the selected CSR operation
  always_comb begin
    w_new = w_old;
    case (funct3[1:0])
      2'b01:   w_new = csr_wr_data;
      2'b10:   w_new = w_old | csr_wr_data;
      2'b11:   w_new = w_old & ~csr_wr_data;
      default: w_new = w_old;
    endcase
  end

  // Trap arbitration: interrupt > illegal > ecall > mret > CSR write.
  assign w_irq_ext    = irq_ext & r_mie[11];
  assign w_irq_tmr    = irq_timer & r_mie[7];
  assign w_irq        = r_mie_bit & boundary_i & (w_irq_ext | w_irq_tmr);
  assign w_trap       = w_irq | illegal_i | ecall_i;
  assign w_mret       = mret_i & ~w_trap;
  assign w_csr_we     = csr_en & ~csr_illegal & w_wr_req & ~w_trap & ~mret_i;
  assign w_cause_code = w_irq ? (w_irq_ext ? 4'd11 : 4'd7) : (illegal_i ? 4'd2 : 4'd11);
  assign w_mcause     = {w_irq, {(XLEN-5){1'b0}}, w_cause_code};

`ifdef CSR_VECTORED_MTVEC_EN
  assign w_vec_off = (w_irq && r_mtvec[1:0] == 2'b01) ? XLEN'({w_cause_code, 2'b00}) : '0;
`else
  assign w_vec_off = '0;
`endif
  assign w_trap_pc = (r_mtvec & c_align4) + w_vec_off;

  // Counter next values; a CSR write replaces only the addressed half.
  always_comb begin
    w_cyc_next = c_wide'(r_mcycle + CNT_WIDTH'(1));
    w_ins_next = c_wide'(r_minstret + CNT_WIDTH'(instret_i));
    if (w_csr_we) begin
      case (csr_addr)
        c_addr_mcycle:    w_cyc_next[XLEN-1:0]      = w_new;
        c_addr_mcycleh:   w_cyc_next[c_wide-1:XLEN] = w_new;
        c_addr_minstret:  w_ins_next[XLEN-1:0]      = w_new;
        c_addr_minstreth: w_ins_next[c_wide-1:XLEN] = w_new;
        default:          ;
      endcase
    end
  end

  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_cyc_next[CNT_WIDTH-1:0];
      r_minstret <= w_ins_next[CNT_WIDTH-1:0];
    end
  end

  // Architectural CSR state: trap entry, mret stacking and CSR writes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mie_bit  <= 1'b0;
      r_mpie_bit <= 1'b0;
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (w_trap) begin
      r_mpie_bit <= r_mie_bit;
      r_mie_bit  <= 1'b0;
      r_mepc     <= (w_irq ? npc_i : pc_i) & c_align4;
      r_mcause   <= w_mcause;
      r_mtval    <= (!w_irq && illegal_i) ? XLEN'(inst_i) : '0;
    end else if (w_mret) begin
      r_mie_bit  <= r_mpie_bit;
      r_mpie_bit <= 1'b1;
    end else if (w_csr_we) begin
      case (csr_addr)
        c_addr_mstatus: begin
          r_mie_bit  <= w_new[3];
          r_mpie_bit <= w_new[7];
        end
        c_addr_mie:      r_mie      <= w_new & c_irq_mask;
        c_addr_mtvec:    r_mtvec    <= w_new & c_mtvec_mask;
        c_addr_mscratch: r_mscratch <= w_new;
        c_addr_mepc:     r_mepc     <= w_new & c_align4;
        c_addr_mcause:   r_mcause   <= w_new;
        c_addr_mtval:    r_mtval    <= w_new;
        default:         ;
      endcase
    end
  end

  // Registered one-cycle redirect pulse towards fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      irq_taken      <= 1'b0;
    end else begin
      redirect_valid <= w_trap | w_mret;
      irq_taken      <= w_irq;
      if (w_trap) begin
        redirect_pc <= w_trap_pc;
      end else if (w_mret) begin
        redirect_pc <= r_mepc;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060077_csr_trap.sv
// ============================================================================
// Module  : tb_ysyx_23060077_csr_trap
// Brief   : Self-checking bench for ysyx_23060077_csr_trap: constant vector
//           table, directed trap/counter sequences and random stimulus
//           against a behavioural model of the CSR/trap rules.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_23060077_csr_trap;

  logic        clock = 1'b0;
  logic        reset, csr_en, ecall_i, illegal_i, mret_i, boundary_i, instret_i;
  logic        irq_timer, irq_ext;
  logic [2:0]  funct3;
  logic [11:0] csr_addr;
  logic [31:0] csr_wr_data, inst_i, pc_i, npc_i;
  logic [31:0] csr_rd_data, redirect_pc, csr_mstatus;
  logic        csr_illegal, redirect_valid, irq_taken;

  always #5 clock = ~clock;

  ysyx_23060077_csr_trap dut (
    .clock(clock), .reset(reset), .csr_en(csr_en), .funct3(funct3),
    .csr_addr(csr_addr), .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data),
    .csr_illegal(csr_illegal), .ecall_i(ecall_i), .illegal_i(illegal_i),
    .mret_i(mret_i), .inst_i(inst_i), .pc_i(pc_i), .npc_i(npc_i),
    .boundary_i(boundary_i), .instret_i(instret_i), .irq_timer(irq_timer),
    .irq_ext(irq_ext), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .csr_mstatus(csr_mstatus), .irq_taken(irq_taken)
  );

`ifdef CSR_VECTORED_MTVEC_EN
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFF;
  localparam bit          VECTORED   = 1'b1;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
  localparam bit          VECTORED   = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit              m_mie, m_mpie;
  logic [31:0]     m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  longint unsigned m_cycle, m_instret;
  bit              e_rv, e_irq;
  logic [31:0]     e_rpc;

  function automatic void m_read(input logic [11:0] a, output bit impl,
                                 output bit ro, output logic [31:0] v);
    impl = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'h300: v = 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h304: v = m_mie_r;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: begin v = (irq_ext ? 32'h800 : 32'h0) + (irq_timer ? 32'h80 : 32'h0); ro = 1'b1; end
      12'hB00: v = m_cycle[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB02: v = m_instret[31:0];
      12'hB82: v = m_instret[63:32];
      12'hF11: begin v = 32'h7973_7978; ro = 1'b1; end
      12'hF12: begin v = 32'h015F_DE7D; ro = 1'b1; end
      default: impl = 1'b0;
    endcase
  endfunction

  // One clock: check combinational outputs, advance model, check registers.
  task automatic tick();
    bit impl, ro, wr, ill, irq, trap, was_reset;
    logic [31:0] old, nv, rd;
    logic [1:0]  op;
    int          code;
    longint unsigned cyc_n, ins_n;
    #1;
    m_read(csr_addr, impl, ro, old);
    op  = funct3[1:0];
    wr  = (op == 2'd1) || (op >= 2'd2 && csr_wr_data != 0);
    ill = csr_en && (!impl || (ro && wr));
    rd  = (csr_en && impl) ? old : 32'h0;
    if (!reset) begin
      chk("rd_data", csr_rd_data, rd);
      chk("csr_illegal", csr_illegal, ill);
    end
    was_reset = reset;
    irq   = m_mie && boundary_i && ((irq_ext && m_mie_r[11]) || (irq_timer && m_mie_r[7]));
    trap  = irq || illegal_i || ecall_i;
    cyc_n = m_cycle + 1;
    ins_n = m_instret + (instret_i ? 1 : 0);
    if (reset) begin
      m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; cyc_n = 0; ins_n = 0;
      e_rv = 0; e_irq = 0; e_rpc = 0;
    end else if (trap) begin
      if (irq) code = (irq_ext && m_mie_r[11]) ? 11 : 7;
      else     code = illegal_i ? 2 : 11;
      e_rpc = (m_mtvec & 32'hFFFF_FFFC) +
              ((irq && m_mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'h0);
      m_mcause = (irq ? 32'h8000_0000 : 32'h0) + 32'(code);
      m_mepc   = (irq ? npc_i : pc_i) & 32'hFFFF_FFFC;
      m_mtval  = (!irq && illegal_i) ? inst_i : 32'h0;
      m_mpie = m_mie; m_mie = 0; e_rv = 1; e_irq = irq;
    end else if (mret_i) begin
      e_rpc = m_mepc; m_mie = m_mpie; m_mpie = 1; e_rv = 1; e_irq = 0;
    end else begin
      e_rv = 0; e_irq = 0;
      if (csr_en && !ill && wr) begin
        nv = (op == 2'd1) ? csr_wr_data : (op == 2'd2) ? (old | csr_wr_data) : (old & ~csr_wr_data);
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_r = nv & 32'h880;
          12'h305: m_mtvec = nv & MTVEC_MASK;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & 32'hFFFF_FFFC;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: cyc_n = {cyc_n[63:32], nv};
          12'hB80: cyc_n = {nv, cyc_n[31:0]};
          12'hB02: ins_n = {ins_n[63:32], nv};
          12'hB82: ins_n = {nv, ins_n[31:0]};
          default: ;
        endcase
      end
    end
    m_cycle = cyc_n; m_instret = ins_n;
    @(posedge clock);
    #1;
    chk("redirect_valid", redirect_valid, e_rv);
    chk("irq_taken", irq_taken, e_irq);
    if (e_rv || was_reset) chk("redirect_pc", redirect_pc, e_rpc);
    chk("csr_mstatus", csr_mstatus, 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0));
  endtask

  task automatic idle();
    csr_en = 0; funct3 = 3'b000; csr_addr = 12'h000; csr_wr_data = 0;
    ecall_i = 0; illegal_i = 0; mret_i = 0; inst_i = 0; pc_i = 0; npc_i = 0;
    boundary_i = 0; instret_i = 0; irq_timer = 0; irq_ext = 0;
  endtask

  task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
    csr_en = 1; funct3 = f3; csr_addr = a; csr_wr_data = d;
  endtask

  // Pure read (CSRRS with zero operand) compared against a constant.
  task automatic rd_expect(input string nm, input logic [11:0] a, input logic [31:0] exp);
    csr_op(3'b010, a, 32'h0);
    #1;
    chk(nm, csr_rd_data, exp);
    tick();
    csr_en = 0;
  endtask

  typedef struct {
    bit          en;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    bit          exp_ill;
  } vec_t;

  vec_t vt [0:25];

  initial begin
    vt[0]  = '{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1800, 1'b0};
    vt[1]  = '{1'b1, 3'b010, 12'hF11, 32'h0,         32'h7973_7978, 1'b0};
    vt[2]  = '{1'b1, 3'b010, 12'hF12, 32'h0,         32'h015F_DE7D, 1'b0};
    vt[3]  = '{1'b1, 3'b001, 12'hF11, 32'h5,         32'h7973_7978, 1'b1};
    vt[4]  = '{1'b1, 3'b010, 12'hF11, 32'h0,         32'h7973_7978, 1'b0};
    vt[5]  = '{1'b1, 3'b011, 12'hF12, 32'h0,         32'h015F_DE7D, 1'b0};
    vt[6]  = '{1'b1, 3'b001, 12'h7C0, 32'h1,         32'h0,         1'b1};
    vt[7]  = '{1'b1, 3'b001, 12'h340, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vt[8]  = '{1'b1, 3'b010, 12'h340, 32'h10,        32'hDEAD_BEEF, 1'b0};
    vt[9]  = '{1'b1, 3'b011, 12'h340, 32'hF,         32'hDEAD_BEFF, 1'b0};
    vt[10] = '{1'b1, 3'b010, 12'h340, 32'h0,         32'hDEAD_BEF0, 1'b0};
    vt[11] = '{1'b1, 3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vt[12] = '{1'b1, 3'b010, 12'h304, 32'h0,         32'h0000_0880, 1'b0};
    vt[13] = '{1'b1, 3'b001, 12'h300, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0};
    vt[14] = '{1'b1, 3'b011, 12'h300, 32'h8,         32'h0000_1888, 1'b0};
    vt[15] = '{1'b1, 3'b010, 12'h300, 32'h0,         32'h0000_1880, 1'b0};
    vt[16] = '{1'b1, 3'b001, 12'h341, 32'h1234_5677, 32'h0,         1'b0};
    vt[17] = '{1'b1, 3'b010, 12'h341, 32'h0,         32'h1234_5674, 1'b0};
    vt[18] = '{1'b0, 3'b001, 12'h340, 32'h1,         32'h0,         1'b0};
    vt[19] = '{1'b1, 3'b010, 12'h340, 32'h0,         32'hDEAD_BEF0, 1'b0};
    vt[20] = '{1'b1, 3'b001, 12'h344, 32'h1,         32'h0,         1'b1};
    vt[21] = '{1'b1, 3'b010, 12'h344, 32'h0,         32'h0,         1'b0};
    vt[22] = '{1'b1, 3'b001, 12'h300, 32'h0,         32'h0000_1880, 1'b0};
    vt[23] = '{1'b1, 3'b001, 12'h304, 32'h0,         32'h0000_0880, 1'b0};
    vt[24] = '{1'b1, 3'b001, 12'h342, 32'hA5,        32'h0,         1'b0};
    vt[25] = '{1'b1, 3'b010, 12'h342, 32'h0,         32'h0000_00A5, 1'b0};

    idle();
    reset = 1;
    repeat (3) tick();
    chk("reset redirect_valid", redirect_valid, 1'b0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset mstatus", csr_mstatus, 32'h1800);
    reset = 0;

    // Constant vector table
    for (int i = 0; i < 26; i++) begin
      csr_en = vt[i].en; funct3 = vt[i].f3; csr_addr = vt[i].addr; csr_wr_data = vt[i].data;
      #1;
      chk($sformatf("vec%0d rd", i), csr_rd_data, vt[i].exp_rd);
      chk($sformatf("vec%0d ill", i), csr_illegal, vt[i].exp_ill);
      tick();
    end
    idle();

    // ecall trap entry
    csr_op(3'b001, 12'h305, 32'h8000_0100); tick();
    csr_op(3'b010, 12'h300, 32'h8);         tick();
    idle(); ecall_i = 1; pc_i = 32'h8000_0040; tick();
    chk("ecall redirect_valid", redirect_valid, 1'b1);
    chk("ecall redirect_pc", redirect_pc, 32'h8000_0100);
    chk("ecall irq_taken", irq_taken, 1'b0);
    idle();
    rd_expect("ecall mepc", 12'h341, 32'h8000_0040);
    chk("redirect pulse ends", redirect_valid, 1'b0);
    rd_expect("ecall mcause", 12'h342, 32'd11);
    rd_expect("ecall mstatus", 12'h300, 32'h1880);

    // mret
    mret_i = 1; tick(); mret_i = 0;
    chk("mret redirect_valid", redirect_valid, 1'b1);
    chk("mret redirect_pc", redirect_pc, 32'h8000_0040);
    rd_expect("mret mstatus", 12'h300, 32'h1888);

    // simultaneous interrupts: external wins, return point is npc
    csr_op(3'b001, 12'h304, 32'h880); tick(); idle();
    irq_timer = 1; irq_ext = 1; boundary_i = 1; pc_i = 32'h8000_0040; npc_i = 32'h8000_0044;
    tick();
    chk("irq redirect_valid", redirect_valid, 1'b1);
    chk("irq irq_taken", irq_taken, 1'b1);
    chk("irq redirect_pc", redirect_pc, 32'h8000_0100);
    tick();
    chk("irq masked by MIE=0", redirect_valid, 1'b0);
    boundary_i = 0;
    rd_expect("irq mcause", 12'h342, 32'h8000_000B);
    rd_expect("irq mepc", 12'h341, 32'h8000_0044);
    idle();

    // illegal beats ecall
    illegal_i = 1; ecall_i = 1; inst_i = 32'hFFFF_FFFF; pc_i = 32'h8000_0080; tick(); idle();
    chk("illegal redirect_pc", redirect_pc, 32'h8000_0100);
    rd_expect("illegal mcause", 12'h342, 32'd2);
    rd_expect("illegal mtval", 12'h343, 32'hFFFF_FFFF);

    // back-to-back traps, trap cancels same-cycle CSR write
    ecall_i = 1; pc_i = 32'h8000_0200; csr_op(3'b001, 12'h340, 32'h1111); tick();
    chk("b2b first", redirect_valid, 1'b1);
    tick();
    chk("b2b second", redirect_valid, 1'b1);
    idle();
    rd_expect("write cancelled", 12'h340, 32'hDEAD_BEF0);

    // counter writes
    csr_op(3'b001, 12'hB00, 32'hFFFF_FFFF); tick(); idle(); tick();
    rd_expect("mcycle low wraps", 12'hB00, 32'h0);
    csr_op(3'b001, 12'hB80, 32'h1234_5678); tick(); idle();
    rd_expect("mcycleh written", 12'hB80, 32'h1234_5678);
    csr_op(3'b001, 12'hB02, 32'h10); instret_i = 1; tick(); idle();
    rd_expect("minstret write wins", 12'hB02, 32'h10);

    // vectored mtvec (or hardwired mode bits)
    csr_op(3'b001, 12'h305, 32'h8000_0101); tick(); idle();
    rd_expect("mtvec readback", 12'h305, VECTORED ? 32'h8000_0101 : 32'h8000_0100);
    csr_op(3'b001, 12'h304, 32'h80); tick();
    csr_op(3'b010, 12'h300, 32'h8);  tick(); idle();
    irq_timer = 1; boundary_i = 1; npc_i = 32'h8000_0300; tick(); idle();
    chk("timer irq_taken", irq_taken, 1'b1);
    chk("timer redirect_pc", redirect_pc, VECTORED ? 32'h8000_011C : 32'h8000_0100);
    ecall_i = 1; tick(); idle();
    chk("exception to base", redirect_pc, 32'h8000_0100);

    // random stimulus against the model
    for (int n = 0; n < 800; n++) begin
      logic [11:0] addrs [0:15];
      addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h7C0, 12'h301};
      csr_en      = ($urandom_range(0, 1) == 1);
      funct3      = 3'($urandom_range(0, 7));
      csr_addr    = addrs[$urandom_range(0, 15)];
      csr_wr_data = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      ecall_i     = ($urandom_range(0, 15) == 0);
      illegal_i   = ($urandom_range(0, 15) == 0);
      mret_i      = ($urandom_range(0, 11) == 0);
      inst_i      = $urandom();
      pc_i        = $urandom();
      npc_i       = $urandom();
      boundary_i  = ($urandom_range(0, 1) == 1);
      instret_i   = ($urandom_range(0, 1) == 1);
      irq_timer   = ($urandom_range(0, 3) == 0);
      irq_ext     = ($urandom_range(0, 3) == 0);
      tick();
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
